uart_rx: RTL and testbench

//  UART receiver; consumes the 16x oversampling baud_clk from the baud-rate generator.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx and the 16x baud_clk, samples mid-bit, and hands bytes over with valid/ack.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SAMPLE    = 16
) (
   input  logic                 SysClk,
   input  logic                 rst,
   input  logic                 baud_clk,
   input  logic                 rx,
   input  logic                 rd_en,
   input  logic                 parity_odd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int TW = $clog2(SAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(SAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HI
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rx_s;
   logic                 baud_meta, baud_s, baud_d;
   logic                 tick;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 tick_clr, tick_inc, shift_en, bit_clr, par_cap, frame_done;
   logic                 mismatch;

   // Two-flop synchronisers; baud_d is the extra stage used for edge detection.
   always_ff @(posedge SysClk or negedge rst) begin
      if (!rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         baud_meta <= 1'b0;
         baud_s    <= 1'b0;
         baud_d    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each flop samples the previous stage's old value.
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         baud_meta <= baud_clk;
         baud_s    <= baud_meta;
         baud_d    <= baud_s;
      end
   end

   assign tick = baud_s & ~baud_d;

   always_ff @(posedge SysClk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt  = state;
      tick_clr   = 1'b0;
      tick_inc   = 1'b0;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      par_cap    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               tick_clr  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == HALF_LAST) begin
                  tick_clr = 1'b1;
                  if (!rx_s) begin
                     state_nxt = DATA;
                     bit_clr   = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  tick_inc = 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt == BIT_LAST) begin
                  tick_clr = 1'b1;
                  shift_en = 1'b1;
                  if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = STOP;
`endif
                  end
               end else begin
                  tick_inc = 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (tick_cnt == BIT_LAST) begin
                  tick_clr  = 1'b1;
                  par_cap   = 1'b1;
                  state_nxt = STOP;
               end else begin
                  tick_inc = 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (tick_cnt == BIT_LAST) begin
                  tick_clr   = 1'b1;
                  frame_done = 1'b1;
                  state_nxt  = rx_s ? IDLE : WAIT_HI;
               end else begin
                  tick_inc = 1'b1;
               end
            end
         end
         WAIT_HI: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: bit counter, tick counter and LSB-first shift register.
   always_ff @(posedge SysClk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         if (tick_clr)      tick_cnt <= '0;
         else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge SysClk or negedge rst) begin
      if (!rst)         par_bit <= 1'b0;
      else if (par_cap) par_bit <= rx_s;
   end

   assign mismatch = (^{shift, par_bit}) != parity_odd;
`else
   logic unused_parity;

   assign unused_parity = parity_odd ^ par_cap;
   assign mismatch      = 1'b0;
`endif

   // A completed frame is only loaded if the previous byte was read or is being read now.
   always_ff @(posedge SysClk or negedge rst) begin
      if (!rst) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else if (frame_done) begin
         if (!rx_valid || rd_en) begin
            rx_data     <= shift;
            rx_valid    <= 1'b1;
            frame_err   <= ~rx_s;
            parity_err  <= mismatch;
            overrun_err <= 1'b0;
         end else begin
            overrun_err <= 1'b1;
         end
      end else if (rd_en && rx_valid) begin
         rx_valid    <= 1'b0;
         overrun_err <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, a monitor checks each new rx_valid.
// Define UART_RX_PARITY_EN for both files to exercise the parity variant.
module tb_uart_rx;

   logic       SysClk = 1'b0;
   logic       rst = 1'b0;
   logic       baud_clk = 1'b0;
   logic       rx = 1'b1;
   logic       rd_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun_err, busy;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   logic prev_valid = 1'b0;

   uart_rx #(.DATA_BITS(8), .SAMPLE(16)) dut (
      .SysClk     (SysClk),
      .rst        (rst),
      .baud_clk   (baud_clk),
      .rx         (rx),
      .rd_en      (rd_en),
      .parity_odd (parity_odd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err),
      .busy       (busy)
   );

   always #5  SysClk   = ~SysClk;
   always #40 baud_clk = ~baud_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Hold rx at v for n oversample periods; rx always changes on a baud_clk falling edge.
   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge baud_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_ticks);
      @(negedge baud_clk);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
      drive_bit(par, 16);
`else
      if (par === 1'bx) drive_bit(1'b1, 0);
`endif
      drive_bit(stop, stop_ticks);
   endtask

   task automatic read_byte();
      @(posedge SysClk);
      #1 rd_en = 1'b1;
      @(posedge SysClk);
      #1 rd_en = 1'b0;
      @(negedge SysClk);
   endtask

   // Monitor: every rising rx_valid must match the oldest expected frame.
   initial begin
      forever begin
         @(negedge SysClk);
         if (rx_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_frame", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("sb_rx_data", 32'(rx_data), 32'(e.data));
               check("sb_frame_err", 32'(frame_err), 32'(e.fe));
               check("sb_parity_err", 32'(parity_err), 32'(e.pe));
            end
         end
         prev_valid = rx_valid;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (4) @(negedge SysClk);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_parity_err", 32'(parity_err), 32'd0);
      check("rst_overrun", 32'(overrun_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge baud_clk);

      // 1: clean frame 0x55, then acknowledge.
      sb.push_back('{data: 8'h55, fe: 1'b0, pe: 1'b0});
      send_frame(8'h55, 1'b0, 1'b1, 16);
      drive_bit(1'b1, 16);
      check("t1_valid", 32'(rx_valid), 32'd1);
      read_byte();
      check("t1_valid_cleared", 32'(rx_valid), 32'd0);
      read_byte();
      check("t1_rd_no_effect", 32'(rx_valid), 32'd0);

      // 2: 5-tick glitch on rx; the start check on the 8th tick returns to IDLE.
      @(negedge baud_clk);
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 1);
      check("t2_busy_mid", 32'(busy), 32'd1);
      drive_bit(1'b1, 1);
      check("t2_busy_before_8th", 32'(busy), 32'd1);
      drive_bit(1'b1, 1);
      check("t2_busy_after_8th", 32'(busy), 32'd0);
      drive_bit(1'b1, 16);
      check("t2_no_valid", 32'(rx_valid), 32'd0);

      // 3: framing error with rx held low for three bit times.
      sb.push_back('{data: 8'hA3, fe: 1'b1, pe: 1'b0});
      send_frame(8'hA3, 1'b0, 1'b0, 48);
      check("t3_wait_hi_busy", 32'(busy), 32'd1);
      check("t3_frame_err", 32'(frame_err), 32'd1);
      read_byte();
      check("t3_valid_cleared", 32'(rx_valid), 32'd0);
      @(negedge baud_clk);
      drive_bit(1'b0, 16);
      check("t3_still_wait_hi", 32'(busy), 32'd1);
      check("t3_no_new_frame", 32'(rx_valid), 32'd0);
      drive_bit(1'b1, 32);
      check("t3_idle_after_hi", 32'(busy), 32'd0);

      // 4: second frame arrives before the first is read -> overrun.
      sb.push_back('{data: 8'h11, fe: 1'b0, pe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b1, 16);
      drive_bit(1'b1, 16);
      send_frame(8'h22, 1'b0, 1'b1, 16);
      drive_bit(1'b1, 16);
      check("t4_data_kept", 32'(rx_data), 32'h11);
      check("t4_overrun", 32'(overrun_err), 32'd1);
      check("t4_valid", 32'(rx_valid), 32'd1);
      read_byte();
      check("t4_valid_cleared", 32'(rx_valid), 32'd0);
      check("t4_overrun_cleared", 32'(overrun_err), 32'd0);

      // 5: reset in the middle of data bit 4, then a full frame 0xC7.
      sb.push_back('{data: 8'h3C, fe: 1'b0, pe: 1'b0});
      send_frame(8'h3C, 1'b0, 1'b1, 16);
      drive_bit(1'b1, 16);
      @(negedge baud_clk);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b0, 16);
      drive_bit(1'b0, 8);
      check("t5_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge SysClk);
      check("t5_rst_valid", 32'(rx_valid), 32'd0);
      check("t5_rst_data", 32'(rx_data), 32'd0);
      check("t5_rst_frame_err", 32'(frame_err), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      rx = 1'b1;
      repeat (4) @(negedge SysClk);
      rst = 1'b1;
      @(negedge baud_clk);
      drive_bit(1'b1, 32);
      check("t5_no_partial", 32'(rx_valid), 32'd0);
      sb.push_back('{data: 8'hC7, fe: 1'b0, pe: 1'b0});
      send_frame(8'hC7, 1'b1, 1'b1, 16);
      drive_bit(1'b1, 16);
      read_byte();

`ifdef UART_RX_PARITY_EN
      // 6: even parity, 0x07 has three ones.
      parity_odd = 1'b0;
      sb.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b1});
      send_frame(8'h07, 1'b0, 1'b1, 16);
      drive_bit(1'b1, 16);
      read_byte();
      sb.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b0});
      send_frame(8'h07, 1'b1, 1'b1, 16);
      drive_bit(1'b1, 16);
      read_byte();
`endif

      repeat (8) @(negedge SysClk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
